// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding and ALU opcodes.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // One spare bit so ptr + k can exceed NREQ-1 before the wrap correction.
  logic [IDW:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW + 1)'(k);
      if (cand >= (IDW + 1)'(NREQ)) begin
        cand = cand - (IDW + 1)'(NREQ);
      end
      if (!any && req[cand[IDW-1:0]]) begin
        any                  = 1'b1;
        gnt[cand[IDW-1:0]]   = 1'b1;
        idx                  = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NREQ requesters: IDLE -> EXEC -> RESP per op.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no round-robin pointer).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned W    = 32,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*2-1:0] req_aluc,
  output logic [W-1:0]    alu_x,
  output logic [W-1:0]    alu_y,
  output logic [1:0]      alu_aluc,
  input  logic [W-1:0]    alu_r,
  input  logic            alu_z,
  input  logic            alu_v,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_r,
  output logic            rsp_z,
  output logic            rsp_v
);

  state_e         state_q, state_d;
  logic [W-1:0]   op_x_q, op_x_d;
  logic [W-1:0]   op_y_q, op_y_d;
  logic [1:0]     op_aluc_q, op_aluc_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   rsp_r_q, rsp_r_d;
  logic           rsp_z_q, rsp_z_d;
  logic           rsp_v_q, rsp_v_d;

  logic [W-1:0]   x_arr    [NREQ];
  logic [W-1:0]   y_arr    [NREQ];
  logic [1:0]     aluc_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign x_arr[g]    = req_x[g*W +: W];
    assign y_arr[g]    = req_y[g*W +: W];
    assign aluc_arr[g] = req_aluc[g*2 +: 2];
  end

  logic [IDW-1:0]  pick_ptr;
  logic [NREQ-1:0] win_gnt;
  logic [IDW-1:0]  win_idx;
  logic            win_any;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  assign pick_ptr = rr_ptr_q;

  // Pointer moves past the requester just served, only once its response is taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == RESP && rsp_ready) begin
      rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_x_d    = op_x_q;
    op_y_d    = op_y_q;
    op_aluc_d = op_aluc_q;
    id_d      = id_q;
    rsp_r_d   = rsp_r_q;
    rsp_z_d   = rsp_z_q;
    rsp_v_d   = rsp_v_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          req_ready = win_gnt;
          op_x_d    = x_arr[win_idx];
          op_y_d    = y_arr[win_idx];
          op_aluc_d = aluc_arr[win_idx];
          id_d      = win_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_r_d = alu_r;
        rsp_z_d = alu_z;
        rsp_v_d = alu_v;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_x_q    <= '0;
      op_y_q    <= '0;
      op_aluc_q <= '0;
      id_q      <= '0;
      rsp_r_q   <= '0;
      rsp_z_q   <= 1'b0;
      rsp_v_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_x_q    <= op_x_d;
      op_y_q    <= op_y_d;
      op_aluc_q <= op_aluc_d;
      id_q      <= id_d;
      rsp_r_q   <= rsp_r_d;
      rsp_z_q   <= rsp_z_d;
      rsp_v_q   <= rsp_v_d;
    end
  end

  assign alu_x     = op_x_q;
  assign alu_y     = op_y_q;
  assign alu_aluc  = op_aluc_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_v     = rsp_v_q;

endmodule
